// File: rtl/encoder_scan_pkg.sv
// Shared types and helpers for the encoder_scan request serializer.
// Holds the state encoding and the lowest-set-bit search.
package encoder_scan_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam int MAX_N = 16;

    // Descending scan so the last hit is the lowest set index.
    function automatic int lsb_idx(input logic [MAX_N-1:0] v);
        int r;
        r = 0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/encoder_scan_lsb_index.sv
// Combinational priority encoder: lowest set index wins.
// Also flags whether any bit is set.
module encoder_scan_lsb_index
    import encoder_scan_pkg::*;
#(
    parameter  int N  = 4,
    localparam int YW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [YW-1:0] idx,
    output logic          any
);

    logic [MAX_N-1:0] ext;

    always_comb begin
        ext        = '0;
        ext[N-1:0] = vec;
    end

    assign idx = YW'(lsb_idx(ext));
    assign any = |vec;

endmodule

// File: rtl/encoder_scan.sv
// Serializes a captured request vector into ascending bit-index codes
// over a valid/ready handshake, then pulses done with the code count.
module encoder_scan
    import encoder_scan_pkg::*;
#(
    parameter  int N  = 4,
    localparam int YW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [N-1:0]  req,
    input  logic          out_ready,
    output logic [YW-1:0] y,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [YW:0]   cnt
);

    localparam logic [N-1:0] VEC_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [YW:0]  CNT_ONE = {{YW{1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [YW-1:0] y_q, y_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [YW:0]   cnt_q, cnt_d;

    logic [N-1:0]  src;
    logic [N-1:0]  src_rest;
    logic [YW-1:0] src_idx;
    logic          src_any;

    // One encoder serves both the load path and the drain path.
    assign src      = (state_q == ST_IDLE) ? req : pending_q;
    assign src_rest = src & (src - VEC_ONE);

    encoder_scan_lsb_index #(.N(N)) u_lsb (
        .vec (src),
        .idx (src_idx),
        .any (src_any)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        y_d       = y_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        cnt_d     = '0;
                        pending_d = '0;
                        if (src_any) begin
                            state_d   = ST_EMIT;
                            valid_d   = 1'b1;
                            y_d       = src_idx;
                            pending_d = src_rest;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (valid_q && out_ready) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (src_any) begin
                            y_d       = src_idx;
                            pending_d = src_rest;
                        end else begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign busy  = (state_q == ST_EMIT);
    assign done  = done_q;
    assign cnt   = cnt_q;

endmodule

// File: tb/tb_encoder_scan.sv
// Scoreboard bench for encoder_scan at N=4.
// Expected codes/counts are queued at load and popped on handshake/done.
module tb_encoder_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] y;
    logic       valid;
    logic       busy;
    logic       done;
    logic [2:0] cnt;

    int total = 0;
    int bad   = 0;
    int exp_y[$];
    int exp_cnt[$];

    encoder_scan #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .req       (req),
        .out_ready (out_ready),
        .y         (y),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_job(input logic [3:0] r);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) begin
                exp_y.push_back(i);
                n++;
            end
        end
        exp_cnt.push_back(n);
    endtask

    task automatic load_job(input logic [3:0] r, input bit push);
        @(posedge clk) #1;
        load = 1'b1;
        req  = r;
        if (push) push_job(r);
        @(posedge clk) #1;
        load = 1'b0;
    endtask

    task automatic wait_done(input int cnt_exp);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        chk("done_seen", int'(hit), 1);
        if (cnt_exp >= 0) begin
            @(negedge clk);
            chk("done_pulse", int'(done), 0);
            chk("cnt_hold", int'(cnt), cnt_exp);
            chk("idle_busy", int'(busy), 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && en === 1'b1 && valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_y.size() == 0) chk("y_extra", int'(y), -1);
            else chk("y", int'(y), exp_y.pop_front());
        end
        if (done === 1'b1) begin
            if (exp_cnt.size() == 0) chk("done_extra", 1, 0);
            else chk("cnt", int'(cnt), exp_cnt.pop_front());
            chk("done_valid", int'(valid), 0);
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0; req = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_y", int'(y), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(cnt), 0);

        // 1011 with ready high: first code one cycle after load
        load_job(4'b1011, 1'b1);
        @(negedge clk);
        chk("lat_valid", int'(valid), 1);
        chk("lat_y", int'(y), 0);
        chk("lat_busy", int'(busy), 1);
        wait_done(3);

        // empty request: done next cycle, never valid or busy
        load_job(4'b0000, 1'b1);
        @(negedge clk);
        chk("zero_done", int'(done), 1);
        chk("zero_valid", int'(valid), 0);
        chk("zero_busy", int'(busy), 0);
        @(negedge clk);
        chk("zero_pulse", int'(done), 0);
        chk("zero_cnt", int'(cnt), 0);

        // backpressure holds the first code
        out_ready = 1'b0;
        load_job(4'b1100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_y", int'(y), 2);
            chk("stall_valid", int'(valid), 1);
            chk("stall_cnt", int'(cnt), 0);
        end
        @(posedge clk) #1;
        out_ready = 1'b1;
        wait_done(2);

        // enable drop mid-job freezes everything
        load_job(4'b0110, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hold_y", int'(y), 1);
            chk("hold_valid", int'(valid), 1);
            chk("hold_cnt", int'(cnt), 0);
            chk("hold_done", int'(done), 0);
        end
        @(posedge clk) #1;
        en = 1'b1;
        wait_done(2);

        // load during EMIT is ignored
        load_job(4'b1111, 1'b1);
        load = 1'b1;
        req  = 4'b0001;
        repeat (2) @(posedge clk);
        #1 load = 1'b0;
        wait_done(-1);

        // back-to-back job accepted in the done cycle
        load = 1'b1;
        req  = 4'b0101;
        push_job(4'b0101);
        @(posedge clk) #1;
        load = 1'b0;
        @(negedge clk);
        chk("b2b_busy", int'(busy), 1);
        wait_done(2);

        // reset after first acceptance abandons the job
        load_job(4'b1111, 1'b0);
        exp_y.push_back(0);
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_rst_y", int'(y), 0);
            chk("mid_rst_valid", int'(valid), 0);
            chk("mid_rst_busy", int'(busy), 0);
            chk("mid_rst_done", int'(done), 0);
            chk("mid_rst_cnt", int'(cnt), 0);
        end
        load_job(4'b1000, 1'b1);
        wait_done(1);

        chk("yq_left", exp_y.size(), 0);
        chk("cntq_left", exp_cnt.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_scan.md
ENCODER_SCAN -- requirements
Module: encoder_scan

Interface
REQ-001 Parameter: N, 4, request vector width; supported values 2..16; verification at N=4.
REQ-002 Parameter: YW, $clog2(N), encoded index width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  enable; when 0, all internal registers and outputs hold, except done.
REQ-006 load  input  1  start strobe; sampled only in IDLE with en=1.
REQ-007 req  input  N  one-hot-or-multi-hot request vector, captured on accepted load.
REQ-008 out_ready  input  1  consumer ready for the current code.
REQ-009 y  output  YW  encoded index of the current request bit, registered.
REQ-010 valid  output  1  y holds a code awaiting acceptance, registered.
REQ-011 busy  output  1  high while in state EMIT, registered.
REQ-012 done  output  1  one-cycle pulse at job end, registered.
REQ-013 cnt  output  YW+1  number of codes accepted in the current/last job, registered.

Function
REQ-014 Two states: IDLE and EMIT; busy = (state==EMIT).
REQ-015 Load accept: state IDLE, en=1, load=1; pending <= req, cnt <= 0.
REQ-016 Accepted load with req!=0: next cycle state=EMIT, valid=1, y=index of lowest set bit of req, that bit cleared from pending.
REQ-017 Accepted load with req==0: state stays IDLE, valid stays 0, done=1 next cycle, cnt=0.
REQ-018 Latency: load at edge k yields first valid code visible after edge k+1's preceding register update (i.e. one cycle after load).
REQ-019 Handshake: a code is accepted in a cycle with valid=1, out_ready=1, en=1; y and valid are stable until accepted.
REQ-020 On acceptance with pending!=0: y <= lowest set index of pending, clear that bit, cnt <= cnt+1, valid stays 1.
REQ-021 On acceptance with pending==0: valid <= 0, cnt <= cnt+1, done <= 1, state <= IDLE.
REQ-022 Codes are emitted strictly in ascending index order; each set bit of captured req emitted exactly once.
REQ-023 load while EMIT is ignored; req changes during EMIT have no effect.
REQ-024 en=0 in any state: pending, state, y, valid, cnt hold; done forced 0; load and out_ready ignored.
REQ-025 done is high for exactly one cycle per job; never asserted while valid=1.
REQ-026 Load accepted in the same cycle done is high is permitted (back-to-back jobs, no bubble beyond done cycle).
REQ-027 cnt after done equals popcount of captured req; holds until next accepted load.

Reset
REQ-028 rst=1 at a clock edge: state=IDLE, pending=0, y=0, valid=0, busy=0, done=0, cnt=0.
REQ-029 rst overrides en, load and out_ready; reset mid-EMIT abandons the job with no done pulse.

Structure
REQ-030 Shared package holds the state encoding (IDLE=0, EMIT=1) and a lowest-set-bit-index function.
REQ-031 One sub-module natural: lsb_index (combinational N-to-YW priority encoder, lowest index wins, plus any-bit flag).
REQ-032 No latches; all outputs driven directly from registers.

Verification
REQ-033 Reset then req=4'b1011, load, out_ready=1 -> y=0,1,3 on consecutive cycles, done one cycle after, cnt=3.
REQ-034 req=4'b0000, load -> valid never 1, done pulses next cycle, cnt=0, busy stays 0.
REQ-035 req=4'b1100, out_ready=0 for 3 cycles -> y=2 valid held 3 cycles; then out_ready=1 -> y=3, then done, cnt=2.
REQ-036 req=4'b0110 mid-job en=0 two cycles -> y/valid/cnt frozen, done=0; resume -> completes with cnt=2.
REQ-037 During EMIT of 4'b1111 load=1 with req=4'b0001 -> ignored, y=0,1,2,3 then done, cnt=4.
REQ-038 rst asserted after first acceptance of 4'b1111 -> next cycle all outputs 0, no done; new load 4'b1000 -> y=3, cnt=1.
